// File: rtl/kanny_pipe_pkg.sv
// Shared constants for the KannyMIPS pipeline registers: stall polarity,
// reset level, stall-vector stage indices and NOP payload field encodings.
package kanny_pipe_pkg;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic RstEnable = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Stall-vector bit positions, upstream to downstream.
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Field encodings a caller packs into a NOP payload.
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [2:0] EXE_RES_NOP = 3'b000;
    localparam logic [4:0] NOPRegAddr  = 5'b00000;

    // What the stage register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } stage_act_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import kanny_pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up, stick at all-ones, drop to zero on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid from stage STAGE to STAGE+1,
// with flush, bubble tagging, hold-age tracking and saturating perf counters.
module pipe_stage_reg
    import kanny_pipe_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                STAGE   = 2,
    parameter int                STALL_W = 6,
    parameter int                CNT_W   = 16,
    parameter int                AGE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  payload_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  payload_o,
    output logic               bubble_o,
    output logic [AGE_W-1:0]   hold_age_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    generate
        if (STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
        end
    endgenerate

    stage_act_e act;
    logic       up_stop;
    logic       dn_stop;
    logic       stall_unused;

    assign up_stop      = (stall[STAGE]   == STOP);
    assign dn_stop      = (stall[STAGE+1] == STOP);
    // Only two bits of the shared vector matter to this stage.
    assign stall_unused = ^stall;

    // Pick exactly one action per edge; the illegal "upstream runs,
    // downstream stops" combination falls through to ADVANCE.
    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (up_stop && !dn_stop) begin
            act = ACT_BUBBLE;
        end else if (!up_stop) begin
            act = ACT_ADVANCE;
        end
    end

    // Valid/payload/bubble flops; HOLD leaves everything untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            valid_o   <= 1'b0;
            payload_o <= NOP_VAL;
            bubble_o  <= 1'b0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    valid_o   <= 1'b0;
                    payload_o <= NOP_VAL;
                    bubble_o  <= 1'b0;
                end
                ACT_BUBBLE: begin
                    valid_o   <= 1'b0;
                    payload_o <= NOP_VAL;
                    bubble_o  <= 1'b1;
                end
                ACT_ADVANCE: begin
                    valid_o   <= valid_i;
                    payload_o <= payload_i;
                    bubble_o  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic held_valid;
    assign held_valid = (act == ACT_HOLD) && valid_o;

    // Age restarts on any action that replaces or kills the contents;
    // perf-counter clear does not touch it.
    sat_counter #(.W(AGE_W)) u_age (
        .clk (clk),
        .rst (rst),
        .inc (held_valid),
        .clr (act != ACT_HOLD),
        .q   (hold_age_o)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (held_valid),
        .clr (cnt_clr),
        .q   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (act == ACT_BUBBLE),
        .clr (cnt_clr),
        .q   (bubble_cnt_o)
    );

    // Only flushes that actually kill live contents are counted.
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((act == ACT_FLUSH) && valid_o),
        .clr (cnt_clr),
        .q   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, corner sequences and random
// monotone-stall traffic against an event-count reference model.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cnt_clr;
    logic        valid_i;
    logic [63:0] payload_i;

    logic        valid_o,   valid_o4;
    logic [63:0] payload_o, payload_o4;
    logic        bubble_o,  bubble_o4;
    logic [3:0]  age_o,     age_o4;
    logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, bubble_cnt4, flush_cnt4;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_i(valid_i), .payload_i(payload_i),
        .valid_o(valid_o), .payload_o(payload_o), .bubble_o(bubble_o),
        .hold_age_o(age_o), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt),
        .flush_cnt_o(flush_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_i(valid_i), .payload_i(payload_i),
        .valid_o(valid_o4), .payload_o(payload_o4), .bubble_o(bubble_o4),
        .hold_age_o(age_o4), .stall_cnt_o(stall_cnt4), .bubble_cnt_o(bubble_cnt4),
        .flush_cnt_o(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stall controller only produces monotone vectors.
    always @(posedge clk) begin
        if (rst) assert (!(stall[3] && !stall[2])) else $error("illegal stall vector");
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference state: contents plus raw event counts since last clear.
    logic        m_valid, m_bub;
    logic [63:0] m_pl;
    longint      m_held, m_st, m_bn, m_fl;

    function automatic longint sat(longint n, int w);
        longint mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_bub = 0; m_pl = '0;
        m_held = 0; m_st = 0; m_bn = 0; m_fl = 0;
    endtask

    task automatic check_all();
        check("valid",       {63'd0, valid_o},   {63'd0, m_valid});
        check("payload",     payload_o,          m_pl);
        check("bubble",      {63'd0, bubble_o},  {63'd0, m_bub});
        check("hold_age",    {60'd0, age_o},     64'(sat(m_held, 4)));
        check("stall_cnt",   {48'd0, stall_cnt}, 64'(sat(m_st, 16)));
        check("bubble_cnt",  {48'd0, bubble_cnt},64'(sat(m_bn, 16)));
        check("flush_cnt",   {48'd0, flush_cnt}, 64'(sat(m_fl, 16)));
        check("valid4",      {63'd0, valid_o4},  {63'd0, m_valid});
        check("payload4",    payload_o4,         m_pl);
        check("stall_cnt4",  {60'd0, stall_cnt4},  64'(sat(m_st, 4)));
        check("bubble_cnt4", {60'd0, bubble_cnt4}, 64'(sat(m_bn, 4)));
        check("flush_cnt4",  {60'd0, flush_cnt4},  64'(sat(m_fl, 4)));
    endtask

    // Apply current inputs for one edge: advance the model, then compare.
    task automatic tick();
        if (flush) begin
            if (m_valid) m_fl++;
            m_valid = 0; m_pl = '0; m_bub = 0; m_held = 0;
        end else if (stall[2] && !stall[3]) begin
            m_bn++;
            m_valid = 0; m_pl = '0; m_bub = 1; m_held = 0;
        end else if (!stall[2]) begin
            m_valid = valid_i; m_pl = payload_i; m_bub = 0; m_held = 0;
        end else if (m_valid) begin
            m_held++; m_st++;
        end
        if (cnt_clr) begin
            m_st = 0; m_bn = 0; m_fl = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic [5:0] s, input logic f, input logic c,
                         input logic v, input logic [63:0] p);
        stall = s; flush = f; cnt_clr = c; valid_i = v; payload_i = p;
    endtask

    // Reset between edges and release between edges.
    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        clr;
        logic        vin;
        logic [63:0] pin;
        logic        e_valid;
        logic [63:0] e_pl;
        logic        e_bub;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst = 1'b0;
        drive(6'b0, 0, 0, 0, '0);
        model_reset();
        #12;
        check_all();
        rst = 1'b1;

        tbl[0] = '{6'b000000, 0, 0, 1, 64'h1234, 1, 64'h1234, 0};
        tbl[1] = '{6'b000111, 0, 0, 1, 64'h4444, 0, 64'h0,    1};
        tbl[2] = '{6'b000000, 0, 0, 1, 64'h55,   1, 64'h55,   0};
        tbl[3] = '{6'b001111, 0, 0, 1, 64'h66,   1, 64'h55,   0};
        tbl[4] = '{6'b111111, 0, 0, 0, 64'h67,   1, 64'h55,   0};
        tbl[5] = '{6'b000111, 1, 0, 1, 64'h68,   0, 64'h0,    0};
        tbl[6] = '{6'b000000, 0, 0, 0, 64'h77,   0, 64'h77,   0};
        tbl[7] = '{6'b000011, 0, 0, 1, 64'h99,   1, 64'h99,   0};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].clr, tbl[i].vin, tbl[i].pin);
            tick();
            check("tbl_valid",   {63'd0, valid_o},  {63'd0, tbl[i].e_valid});
            check("tbl_payload", payload_o,         tbl[i].e_pl);
            check("tbl_bubble",  {63'd0, bubble_o}, {63'd0, tbl[i].e_bub});
        end

        // Async reset with live contents.
        drive(6'b0, 0, 0, 1, 64'hDEAD_BEEF);
        tick();
        async_reset();
        check("rst_valid",   {63'd0, valid_o}, 64'd0);
        check("rst_payload", payload_o,        64'd0);

        // Long hold: age and narrow stall counter saturate, wide one does not.
        drive(6'b0, 0, 0, 1, 64'hA5);
        tick();
        drive(6'b001111, 0, 0, 0, 64'h0);
        for (int i = 0; i < 20; i++) tick();
        check("hold_payload", payload_o,               64'hA5);
        check("hold_age_sat", {60'd0, age_o},          64'd15);
        check("hold_stall20", {48'd0, stall_cnt},      64'd20);
        check("hold_stall4",  {60'd0, stall_cnt4},     64'd15);
        cnt_clr = 1'b1;
        tick();
        check("clr_stall",  {48'd0, stall_cnt},  64'd0);
        check("clr_stall4", {60'd0, stall_cnt4}, 64'd0);
        cnt_clr = 1'b0;
        tick();
        check("post_clr_stall", {48'd0, stall_cnt}, 64'd1);

        // Flush wins over a bubble-forming stall.
        drive(6'b000111, 1, 0, 1, 64'hBB);
        tick();
        check("flush_valid",  {63'd0, valid_o},    64'd0);
        check("flush_bubble", {63'd0, bubble_o},   64'd0);
        check("flush_cnt1",   {48'd0, flush_cnt},  64'd1);
        check("flush_bcnt",   {48'd0, bubble_cnt}, 64'd0);

        // Reset in the middle of a hold discards the held payload.
        drive(6'b0, 0, 0, 1, 64'hC0FFEE);
        tick();
        drive(6'b011111, 0, 0, 1, 64'h1);
        for (int i = 0; i < 3; i++) tick();
        async_reset();
        check("midhold_payload", payload_o,      64'd0);
        check("midhold_age",     {60'd0, age_o}, 64'd0);

        // Random monotone stall traffic.
        for (int i = 0; i < 600; i++) begin
            int k;
            k = $urandom_range(0, 6);
            drive(6'((1 << k) - 1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom), {$urandom, $urandom});
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
